uart_rx: RTL and testbench
==========================

# uart_rx

UART receive engine for the serial link. It oversamples the synchronized `rx` line using tick enables from `baudrate_gen`. It detects and validates start bits, shifts in LSB-first data, checks the stop bit, and presents each received byte with a one-cycle valid strobe. It also drives `rx_active` back to `baudrate_gen`, so the tick counter runs only during a frame and is phase-aligned to the start edge.

## Interface
- `DATA_BITS`, default 8: data bits per frame, range 5–9.
- `TICKS_PER_BIT`, default 16: `baud_tick` pulses per bit period. Must be even and ≥4. Integration sets it to match the generator's rx tick rate.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial line, asynchronous to `clk`. Idle level is 1.
- `baud_tick` in 1: one-`clk` enable pulse from `baudrate_gen` `baud_en_rx`.
- `rx_active` out 1: request to `baudrate_gen` to run the rx tick counter.
- `data_out` out DATA_BITS: last correctly framed word. Holds its value until the next valid frame.
- `data_valid` out 1: one-`clk` pulse when `data_out` is updated.
- `frame_err` out 1: one-`clk` pulse when the stop bit is sampled as 0.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer; `rxs` is the synchronized value.
- IDLE:
  - Waits for `rxs` == 0.
  - On that condition, goes to START, clears the tick counter, and sets `rx_active` = 1.
- START:
  - Counts `baud_tick` pulses.
  - At tick TICKS_PER_BIT/2 − 1 (mid start bit), samples `rxs`.
  - If `rxs` == 0: go to DATA, clear the tick and bit counters.
  - If `rxs` == 1: false start. Go to IDLE and drop `rx_active`. No strobes.
- DATA:
  - Counts ticks.
  - At tick TICKS_PER_BIT − 1, samples `rxs` into the shift register MSB and shifts right (LSB-first), clears the tick counter, and increments the bit counter.
  - After DATA_BITS samples, goes to STOP.
- STOP:
  - At tick TICKS_PER_BIT − 1, samples `rxs`.
  - If `rxs` == 1: load `data_out`, pulse `data_valid`, go to IDLE.
  - If `rxs` == 0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
- BREAK:
  - Waits until `rxs` == 1, then goes to IDLE. This prevents a held-low line from retriggering.
  - `rx_active` = 0 in BREAK.
- `rx_active` is 1 exactly in START, DATA and STOP.
- Counter widths:
  - Tick counter: `$clog2(TICKS_PER_BIT)` bits.
  - Bit counter: `$clog2(DATA_BITS+1)` bits.
  - Neither counter wraps; each is cleared explicitly at every transition.
- `baud_tick` is ignored in IDLE and BREAK.

## Timing
- Reset values:
  - State: IDLE.
  - `rx_active`, `data_valid`, `frame_err`, `busy` = 0.
  - `data_out` = 0.
  - Shift register and counters = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. No strobe is produced for the aborted frame.
- Latency from `rx` to IDLE exit: 2 `clk` (synchronizer) + 1 `clk` (registered state).
- `data_valid` / `frame_err`:
  - Go high on the `clk` edge that consumes the stop-bit sample tick.
  - Stay high for exactly 1 cycle.
  - Are never both high.
- Bit sampling points fall at the bit centre relative to the start detection, within ±1 tick.
- Back-to-back frames:
  - A new start bit is accepted in the first IDLE cycle after the stop sample.
  - Minimum stop-bit length is therefore half a bit.
- `baud_tick` arriving in the same cycle as a state transition counts toward the state being left. It is not carried into the new state.

## Structure
- `uart_pkg` holds:
  - The state enum: IDLE, START, DATA, STOP, BREAK.
  - Default constants `UART_DATA_BITS` = 8 and `UART_TICKS_PER_BIT` = 16, shared with the future `uart_tx`.
- Sub-module `sync_2ff`: a generic single-bit synchronizer with a reset value parameter. It is reused by other asynchronous inputs.
- Everything else stays flat in `uart_rx`: FSM, counters, shift register.

## Test plan
Conditions for scenarios 1–5: TICKS_PER_BIT = 16, `baud_tick` tied to 1, so one bit = 16 `clk`.

1. Send 0xA5, 8N1 → `data_out` = 0xA5. One `data_valid` pulse about 152 `clk` after the start edge. `frame_err` stays 0. `rx_active` falls after the stop sample.
2. Low glitch of 5 `clk`, then high → no strobes. Returns to IDLE. `rx_active` high only about 8 cycles. `data_out` unchanged.
3. Send 0x3C with the stop bit driven 0 and held low 40 `clk` → one `frame_err` pulse, no `data_valid`, `data_out` keeps 0xA5. No START entered until `rx` returns high.
4. Back-to-back 0x00 then 0xFF, each with a 1-bit stop and no gap → two `data_valid` pulses, with values 0x00 and 0xFF in order.
5. Assert `rst` during data bit 3 of 0x77 → all outputs 0 within the same cycle. After release, 0x5A is received correctly.
6. Integrate with `baudrate_gen` (100 MHz, 115200 baud), frame 0x81 at that bit rate → `data_valid` with 0x81. `baud_tick` appears only while `rx_active` = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit engines.
//   - rx_state_t    : receiver FSM states
//   - UART_DATA_BITS, UART_TICKS_PER_BIT : default frame/oversampling constants
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer for asynchronous inputs.
//   clk  in  : destination clock
//   rst  in  : asynchronous active-high reset; both flops load RESET_VAL
//   d    in  : asynchronous input
//   q    out : synchronized output (2 clk latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {2{RESET_VAL}};
    else     sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receive engine (LSB-first, one stop bit).
//   clk        in  : system clock
//   rst        in  : asynchronous active-high reset
//   rx         in  : serial line, asynchronous, idle high
//   baud_tick  in  : one-clk oversampling enable from the baud generator
//   rx_active  out : asks the baud generator to run its rx tick counter
//   data_out   out : last correctly framed word, held until the next one
//   data_valid out : one-clk strobe when data_out is updated
//   frame_err  out : one-clk strobe when the stop bit is sampled low
//   busy       out : high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = UART_DATA_BITS,
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 rx_active,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] MID_TICK = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] END_TICK = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic mid_hit, end_hit;
  logic bit_smp, load_data, raise_err;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  assign mid_hit = baud_tick && (tick_cnt == MID_TICK);
  assign end_hit = baud_tick && (tick_cnt == END_TICK);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxs)   state_nxt = START;
      START:   if (mid_hit) state_nxt = rxs ? IDLE : DATA;
      DATA:    if (end_hit && (bit_cnt == LAST_BIT)) state_nxt = STOP;
      STOP:    if (end_hit) state_nxt = rxs ? IDLE : BREAK;
      BREAK:   if (rxs)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    rx_active = (state == START) || (state == DATA) || (state == STOP);
    busy      = (state != IDLE);
    bit_smp   = (state == DATA) && end_hit;
    load_data = (state == STOP) && end_hit &&  rxs;
    raise_err = (state == STOP) && end_hit && !rxs;
  end

  // Counters, shift register and strobes. Any state change clears both
  // counters, so a tick coinciding with a transition is not carried over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load_data;
      frame_err  <= raise_err;

      if (load_data) data_out <= shreg;

      // LSB arrives first: insert at MSB and shift right.
      if (bit_smp) shreg <= {rxs, shreg[DATA_BITS-1:1]};

      if ((state_nxt != state) || bit_smp) tick_cnt <= '0;
      else if (rx_active && baud_tick)     tick_cnt <= tick_cnt + TW'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_smp)       bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (8 data bits,
// 16 ticks per bit). Scenarios 1-5 tie baud_tick high; scenario 6 uses a
// small behavioural stand-in for the baud generator (100 MHz, 115200 baud).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       baud_tick;
  logic       rx_active;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DATA_BITS(8), .TICKS_PER_BIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .rx_active  (rx_active),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Baud generator stand-in: 100e6 / (115200*16) ~= 54 clk per tick,
  // counter held in reset while rx_active is low so ticks are phase-aligned.
  logic gen_mode = 1'b0;
  int   gcnt     = 0;
  always @(posedge clk) begin
    if (!rx_active)     gcnt <= 0;
    else if (gcnt == 53) gcnt <= 0;
    else                gcnt <= gcnt + 1;
  end
  assign baud_tick = gen_mode ? (rx_active && (gcnt == 53)) : 1'b1;

  // Output monitor, sampled on the inactive edge.
  int         nval = 0, nferr = 0, nboth = 0, nact = 0, ntick = 0, vcyc = 0;
  logic [7:0] vq[$];
  always @(negedge clk) begin
    if (data_valid) begin
      nval++;
      vq.push_back(data_out);
      vcyc = cyc;
    end
    if (frame_err)               nferr++;
    if (data_valid && frame_err) nboth++;
    if (rx_active)               nact++;
    if (baud_tick)               ntick++;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int t0 = 0;

  // Drives start, 8 data bits LSB-first and a stop level; leaves rx at stop.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int stop_clks, input int bt);
    rx = 1'b0;
    t0 = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bt) @(negedge clk);
    end
    rx = stop;
    repeat (stop_clks) @(negedge clk);
  endtask

  int b_val, b_err, b_act, b_tick, idx;
  logic [7:0] frm;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: 0xA5, 8N1. Start seen 3 clk after rx falls, start mid-sample 8
    // ticks later, then 9 x 16 ticks to the stop sample: 3 + 8 + 144 = 155.
    b_val = nval; b_err = nferr; b_act = nact;
    send_frame(8'hA5, 1'b1, 16, 16);
    repeat (20) @(negedge clk);
    chk("s1_valid_cnt", nval - b_val, 1);
    chk("s1_data", data_out, 8'hA5);
    chk("s1_latency", vcyc - t0, 155);
    chk("s1_ferr_cnt", nferr - b_err, 0);
    chk("s1_active_cycles", nact - b_act, 152);
    chk("s1_active_low", rx_active, 0);

    // 2: 5-clk low glitch, rejected at the mid-start sample.
    b_val = nval; b_err = nferr; b_act = nact;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("s2_valid_cnt", nval - b_val, 0);
    chk("s2_ferr_cnt", nferr - b_err, 0);
    chk("s2_active_cycles", nact - b_act, 8);
    chk("s2_busy", busy, 0);
    chk("s2_data", data_out, 8'hA5);

    // 3: 0x3C with stop low, line held low 40 clk -> framing error, BREAK.
    b_val = nval; b_err = nferr; b_act = nact;
    send_frame(8'h3C, 1'b0, 40, 16);
    chk("s3_break_busy", busy, 1);
    chk("s3_break_inactive", rx_active, 0);
    chk("s3_ferr_cnt", nferr - b_err, 1);
    chk("s3_valid_cnt", nval - b_val, 0);
    chk("s3_data_kept", data_out, 8'hA5);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("s3_idle_busy", busy, 0);
    chk("s3_active_cycles", nact - b_act, 152);

    // 4: back-to-back 0x00 then 0xFF with one-bit stop, no gap.
    b_val = nval; b_err = nferr; idx = vq.size();
    send_frame(8'h00, 1'b1, 16, 16);
    send_frame(8'hFF, 1'b1, 16, 16);
    repeat (20) @(negedge clk);
    chk("s4_valid_cnt", nval - b_val, 2);
    chk("s4_ferr_cnt", nferr - b_err, 0);
    chk("s4_first", (vq.size() > idx) ? 32'(vq[idx]) : 32'hDEAD, 8'h00);
    chk("s4_second", (vq.size() > idx + 1) ? 32'(vq[idx + 1]) : 32'hDEAD, 8'hFF);

    // 5: reset during data bit 3 of 0x77, then receive 0x5A.
    b_val = nval; b_err = nferr;
    frm = 8'h77;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = frm[i];
      repeat (16) @(negedge clk);
    end
    rx = frm[3];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s5_rst_rx_active", rx_active, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_data_out", data_out, 0);
    chk("s5_rst_strobes", {data_valid, frame_err}, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1, 16, 16);
    repeat (20) @(negedge clk);
    chk("s5_valid_cnt", nval - b_val, 1);
    chk("s5_ferr_cnt", nferr - b_err, 0);
    chk("s5_data", data_out, 8'h5A);

    // 6: generator-driven ticks, line at 868 clk/bit (115200 baud).
    // A frame consumes 8 + 9*16 = 152 ticks, then rx_active stops them.
    gen_mode = 1'b1;
    repeat (5) @(negedge clk);
    b_val = nval; b_err = nferr; b_tick = ntick;
    send_frame(8'h81, 1'b1, 868, 868);
    repeat (100) @(negedge clk);
    chk("s6_valid_cnt", nval - b_val, 1);
    chk("s6_ferr_cnt", nferr - b_err, 0);
    chk("s6_data", data_out, 8'h81);
    chk("s6_tick_cnt", ntick - b_tick, 152);

    chk("never_both_strobes", nboth, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
